// File: rtl/hook_rope_controller.sv
`default_nettype none
// ============================================================================
// Module      : hook_rope_controller
// Description : Gold Miner claw rope endpoint generator. A SWING/EXTEND/RETRACT
//               state machine, advanced by the per-frame tick, maintains an
//               angle index and a rope length. The endpoint is computed from
//               them through a Q7 cos/sin table and registered.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   system clock
//   resetN       in   asynchronous active-low reset
//   startOfFrame in   one-cycle pulse per VGA frame
//   fire         in   launch request (level or pulse)
//   collision    in   hook tip hit an object or the screen border
//   weight       in   [2:0] weight of the caught object, unsigned
//   x_end        out  [10:0] signed rope endpoint x
//   y_end        out  [10:0] signed rope endpoint y
//   state_out    out  [1:0] 00 SWING, 01 EXTEND, 10 RETRACT
//   retract_done out  one-cycle pulse when the rope is back at MIN_LEN
//   caught       out  valid with retract_done: 1 = retract caused by collision
// ============================================================================
module hook_rope_controller #(
  parameter int X_START       = 300,
  parameter int Y_START       = 0,
  parameter int MIN_LEN       = 20,
  parameter int MAX_LEN       = 400,
  parameter int EXTEND_SPEED  = 4,
  parameter int RETRACT_SPEED = 8,
  parameter int SWING_DIV     = 2
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               fire,
  input  logic               collision,
  input  logic [2:0]         weight,
  output logic signed [10:0] x_end,
  output logic signed [10:0] y_end,
  output logic [1:0]         state_out,
  output logic               retract_done,
  output logic               caught
);

  localparam int             DIV_W     = (SWING_DIV > 1) ? $clog2(SWING_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SWING_DIV - 1);
  localparam logic [8:0]     MIN_LEN_V = 9'(MIN_LEN);
  localparam logic [8:0]     MAX_LEN_V = 9'(MAX_LEN);
  localparam logic [10:0]    X_RESET   = 11'(X_START);
  localparam logic [10:0]    Y_RESET   = 11'(Y_START + MIN_LEN);

  typedef enum logic [1:0] {
    ST_SWING   = 2'b00,
    ST_EXTEND  = 2'b01,
    ST_RETRACT = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic               dir_up_q, dir_up_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [8:0]         len_q, len_d;
  logic               caught_q, caught_d;
  logic               retract_done_q, retract_done_d;
  logic signed [10:0] x_end_q, x_end_d;
  logic signed [10:0] y_end_q, y_end_d;

  logic signed [8:0]  cos_v, sin_v;
  logic signed [17:0] prod_x, prod_y;
  logic [9:0]         len_grow;
  logic [8:0]         step;

  // Q7 trig table, angle = 10 + 20*idx degrees, y axis pointing down.
  function automatic logic signed [8:0] cos_q7(input logic [3:0] i);
    case (i)
      4'd0:    cos_q7 = 9'sd126;
      4'd1:    cos_q7 = 9'sd111;
      4'd2:    cos_q7 = 9'sd82;
      4'd3:    cos_q7 = 9'sd44;
      4'd4:    cos_q7 = 9'sd0;
      4'd5:    cos_q7 = -9'sd44;
      4'd6:    cos_q7 = -9'sd82;
      4'd7:    cos_q7 = -9'sd111;
      4'd8:    cos_q7 = -9'sd126;
      default: cos_q7 = 9'sd0;
    endcase
  endfunction

  function automatic logic signed [8:0] sin_q7(input logic [3:0] i);
    case (i)
      4'd0, 4'd8: sin_q7 = 9'sd22;
      4'd1, 4'd7: sin_q7 = 9'sd64;
      4'd2, 4'd6: sin_q7 = 9'sd98;
      4'd3, 4'd5: sin_q7 = 9'sd120;
      4'd4:       sin_q7 = 9'sd128;
      default:    sin_q7 = 9'sd0;
    endcase
  endfunction

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    dir_up_d       = dir_up_q;
    div_d          = div_q;
    len_d          = len_q;
    caught_d       = caught_q;
    retract_done_d = 1'b0;

    len_grow = {1'b0, len_q} + 10'(EXTEND_SPEED);
    // Heavier loads retract slower, but never stall completely.
    if ({6'd0, weight} < 9'(RETRACT_SPEED)) begin
      step = 9'(RETRACT_SPEED) - {6'd0, weight};
    end else begin
      step = 9'd1;
    end

    case (state_q)
      ST_SWING: begin
        // A launch takes precedence over an angle step in the same cycle.
        if (fire) begin
          state_d  = ST_EXTEND;
          caught_d = 1'b0;
        end else if (startOfFrame) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (dir_up_q) begin
              idx_d = idx_q + 4'd1;
              if (idx_q == 4'd7) dir_up_d = 1'b0;
            end else begin
              idx_d = idx_q - 4'd1;
              if (idx_q == 4'd1) dir_up_d = 1'b1;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      ST_EXTEND: begin
        if (collision) begin
          state_d  = ST_RETRACT;
          caught_d = 1'b1;
        end else if (startOfFrame) begin
          if (len_grow >= {1'b0, MAX_LEN_V}) begin
            len_d    = MAX_LEN_V;
            state_d  = ST_RETRACT;
            caught_d = 1'b0;
          end else begin
            len_d = len_grow[8:0];
          end
        end
      end
      ST_RETRACT: begin
        if (startOfFrame) begin
          if ({1'b0, len_q} <= ({1'b0, MIN_LEN_V} + {1'b0, step})) begin
            len_d          = MIN_LEN_V;
            state_d        = ST_SWING;
            retract_done_d = 1'b1;
          end else begin
            len_d = len_q - step;
          end
        end
      end
      default: begin
        state_d = ST_SWING;
      end
    endcase

    // Endpoint follows the current len/idx registers, hence one cycle behind.
    cos_v   = cos_q7(idx_q);
    sin_v   = sin_q7(idx_q);
    prod_x  = $signed({9'd0, len_q}) * $signed({{9{cos_v[8]}}, cos_v});
    prod_y  = $signed({9'd0, len_q}) * $signed({{9{sin_v[8]}}, sin_v});
    // Bits [17:7] are the arithmetic >>>7 result (floor toward -inf).
    x_end_d = $signed(X_RESET + prod_x[17:7]);
    y_end_d = $signed(11'(Y_START) + prod_y[17:7]);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= ST_SWING;
      idx_q          <= 4'd4;
      dir_up_q       <= 1'b1;
      div_q          <= '0;
      len_q          <= MIN_LEN_V;
      caught_q       <= 1'b0;
      retract_done_q <= 1'b0;
      x_end_q        <= $signed(X_RESET);
      y_end_q        <= $signed(Y_RESET);
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      dir_up_q       <= dir_up_d;
      div_q          <= div_d;
      len_q          <= len_d;
      caught_q       <= caught_d;
      retract_done_q <= retract_done_d;
      x_end_q        <= x_end_d;
      y_end_q        <= y_end_d;
    end
  end

  assign x_end        = x_end_q;
  assign y_end        = y_end_q;
  assign state_out    = state_q;
  assign retract_done = retract_done_q;
  assign caught       = caught_q;

endmodule
`default_nettype wire

// File: tb/tb_hook_rope_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_hook_rope_controller
// Description : Directed bench for hook_rope_controller with a frame-level
//               behavioural model compared against the DUT every cycle, plus
//               hand-computed endpoint and timing expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hook_rope_controller;

  localparam int X_START = 300, Y_START = 0, MIN_LEN = 20, MAX_LEN = 400;
  localparam int EXTEND_SPEED = 4, RETRACT_SPEED = 8, SWING_DIV = 2;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame, fire, collision;
  logic [2:0]         weight;
  logic signed [10:0] x_end, y_end;
  logic [1:0]         state_out;
  logic               retract_done, caught;

  int checks = 0, failures = 0;
  int pulses = 0, last_caught = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  hook_rope_controller #(
    .X_START(X_START), .Y_START(Y_START), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN),
    .EXTEND_SPEED(EXTEND_SPEED), .RETRACT_SPEED(RETRACT_SPEED), .SWING_DIV(SWING_DIV)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fire(fire),
    .collision(collision), .weight(weight), .x_end(x_end), .y_end(y_end),
    .state_out(state_out), .retract_done(retract_done), .caught(caught)
  );

  // ---------------- behavioural model (integer, frame-level) ----------------
  int COS_T [0:8] = '{126, 111, 82, 44, 0, -44, -82, -111, -126};
  int SIN_T [0:8] = '{22, 64, 98, 120, 128, 120, 98, 64, 22};

  int m_state, m_idx, m_dir, m_div, m_len, m_caught, m_done, m_x, m_y;

  function automatic int floor128(input int p);
    int q;
    q = p / 128;
    if (p < 0 && (p % 128) != 0) q = q - 1;
    return q;
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_state <= 0; m_idx <= 4; m_dir <= 1; m_div <= 0; m_len <= MIN_LEN;
      m_caught <= 0; m_done <= 0; m_x <= X_START; m_y <= Y_START + MIN_LEN;
    end else begin : mdl
      int st, ix, dr, dv, ln, ca, dn, stp;
      st = m_state; ix = m_idx; dr = m_dir; dv = m_div; ln = m_len; ca = m_caught; dn = 0;
      stp = RETRACT_SPEED - int'(weight);
      if (stp < 1) stp = 1;
      if (st == 0) begin
        if (fire) begin
          st = 1; ca = 0;
        end else if (startOfFrame) begin
          dv = dv + 1;
          if (dv == SWING_DIV) begin
            dv = 0;
            ix = ix + dr;
            if (ix == 8) dr = -1;
            if (ix == 0) dr = 1;
          end
        end
      end else if (st == 1) begin
        if (collision) begin
          st = 2; ca = 1;
        end else if (startOfFrame) begin
          if (ln + EXTEND_SPEED >= MAX_LEN) begin
            ln = MAX_LEN; st = 2; ca = 0;
          end else begin
            ln = ln + EXTEND_SPEED;
          end
        end
      end else begin
        if (startOfFrame) begin
          if (ln <= MIN_LEN + stp) begin
            ln = MIN_LEN; st = 0; dn = 1;
          end else begin
            ln = ln - stp;
          end
        end
      end
      m_x <= X_START + floor128(m_len * COS_T[m_idx]);
      m_y <= Y_START + floor128(m_len * SIN_T[m_idx]);
      m_state <= st; m_idx <= ix; m_dir <= dr; m_div <= dv; m_len <= ln;
      m_caught <= ca; m_done <= dn;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (check_en) begin
        check("model x_end", int'(x_end), m_x);
        check("model y_end", int'(y_end), m_y);
        check("model state_out", int'(state_out), m_state);
        check("model retract_done", int'(retract_done), m_done);
        check("model caught", int'(caught), m_caught);
      end
      if (retract_done === 1'b1) begin
        pulses++;
        last_caught = int'(caught);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1; cyc(1);
      startOfFrame = 1'b0; cyc(1);
    end
  endtask

  task automatic pulse_fire();
    fire = 1'b1; cyc(1);
    fire = 1'b0; cyc(1);
  endtask

  task automatic check_xy(input string name, input int ex, input int ey);
    check({name, " x"}, int'(x_end), ex);
    check({name, " y"}, int'(y_end), ey);
  endtask

  task automatic stimulus();
    int p0;
    resetN = 1'b0; startOfFrame = 1'b0; fire = 1'b0; collision = 1'b0; weight = 3'd0;
    cyc(1);
    check_en = 1'b1;
    cyc(2);
    resetN = 1'b1;
    cyc(5);

    // 1: idle after reset
    check_xy("reset", 300, 20);
    check("reset state", int'(state_out), 0);
    check("reset done", int'(retract_done), 0);

    // 2: swing to the right end and back one step
    tick(8);
    check_xy("idx8", 280, 3);
    tick(2);
    check_xy("idx7", 282, 10);

    // 3: fire at idx 4, extend 10 ticks, collide, retract with step 5
    tick(6);
    check_xy("idx4", 300, 20);
    pulse_fire();
    check("extend state", int'(state_out), 1);
    tick(10);
    check_xy("len60", 300, 60);
    weight = 3'd3;
    collision = 1'b1; cyc(1);
    collision = 1'b0; cyc(1);
    check("collide state", int'(state_out), 2);
    p0 = pulses;
    tick(7);
    check("retract7 state", int'(state_out), 2);
    check("retract7 pulses", pulses - p0, 0);
    tick(1);
    check("retract8 pulses", pulses - p0, 1);
    check("retract8 caught", last_caught, 1);
    check("retract8 state", int'(state_out), 0);

    // 4: fire at idx 0, run to MAX_LEN, slow retract with step 1
    tick(8);
    check_xy("idx0", 319, 3);
    weight = 3'd7;
    pulse_fire();
    tick(94);
    check("ext94 state", int'(state_out), 1);
    tick(1);
    check("ext95 state", int'(state_out), 2);
    check_xy("len400", 693, 68);
    p0 = pulses;
    tick(379);
    check("slow379 pulses", pulses - p0, 0);
    tick(1);
    check("slow380 pulses", pulses - p0, 1);
    check("slow380 caught", last_caught, 0);
    check("slow380 state", int'(state_out), 0);

    // 5: simultaneous fire+tick, then simultaneous collision+tick
    weight = 3'd0;
    tick(1);
    startOfFrame = 1'b1; fire = 1'b1; cyc(1);
    startOfFrame = 1'b0; fire = 1'b0; cyc(1);
    check("fire+sof state", int'(state_out), 1);
    check_xy("fire+sof", 319, 3);
    startOfFrame = 1'b1; collision = 1'b1; cyc(1);
    startOfFrame = 1'b0; collision = 1'b0; cyc(1);
    check("col+sof state", int'(state_out), 2);
    check_xy("col+sof", 319, 3);
    p0 = pulses;
    tick(1);
    check("short retract pulses", pulses - p0, 1);
    check("short retract caught", last_caught, 1);
    tick(1);
    check_xy("idx1 resume", 317, 10);

    // 6: reset in the middle of EXTEND at len 200
    pulse_fire();
    tick(45);
    check("len200 state", int'(state_out), 1);
    check_xy("len200", 473, 100);
    p0 = pulses;
    #2 resetN = 1'b0;
    #1;
    check("async rst state", int'(state_out), 0);
    check_xy("async rst", 300, 20);
    check("async rst done", int'(retract_done), 0);
    check("async rst caught", int'(caught), 0);
    cyc(2);
    resetN = 1'b1;
    cyc(5);
    check("post rst pulses", pulses - p0, 0);
    check_xy("post rst", 300, 20);
    cyc(2);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #200000;
        checks++;
        failures++;
        $display("FAIL watchdog: stimulus did not complete within time limit");
      end
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
